alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
- REQ-001: Parameter WIDTH, default 4, operand and result width in bits (WIDTH >= 2).
- REQ-002: clk  input  1  rising-edge clock for the output register.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: opcode  input  4  operation select; values come from package alu_ops.
- REQ-005: a  input  WIDTH  first operand; the shifted value for shift ops.
- REQ-006: b  input  WIDTH  second operand; the unsigned shift amount for shift ops.
- REQ-007: cin  input  1  carry-in for ADD and borrow-in for SUB; ignored by all other ops.
- REQ-008: y  output  WIDTH  registered result.
- REQ-009: cout  output  1  registered carry-out for ADD or borrow-out for SUB.
- REQ-010: overflow  output  1  registered two's-complement signed overflow.
- REQ-011: negative  output  1  registered copy of y[WIDTH-1].
- REQ-012: zero  output  1  registered flag, 1 when y == 0.

Function
- REQ-013: All results and flags SHALL be computed combinationally from opcode, a, b and cin, then captured on each rising clk edge; latency is exactly 1 cycle, with no handshake and no enable.
- REQ-014: ADD_OP SHALL produce y = (a + b + cin) mod 2^WIDTH, with cout = carry out of bit WIDTH-1.
- REQ-015: SUB_OP SHALL produce y = (a - b - cin) mod 2^WIDTH, with cout = 1 when the unsigned value a < b + cin (borrow) and 0 otherwise.
- REQ-016: For ADD and SUB, overflow SHALL be 1 when the signed result does not fit in WIDTH bits; for every other op, overflow = 0.
- REQ-017: For all ops other than ADD and SUB, cout SHALL be 0.
- REQ-018: AND_OP, OR_OP and XOR_OP SHALL produce the bitwise a&b, a|b and a^b respectively.
- REQ-019: NOT_OP SHALL produce y = ~a, and b SHALL be ignored.
- REQ-020: LL_SHIFT_OP and AL_SHIFT_OP SHALL both produce a << b with zero fill; when b >= WIDTH, y = 0.
- REQ-021: LR_SHIFT_OP SHALL produce a >> b with zero fill; when b >= WIDTH, y = 0.
- REQ-022: AR_SHIFT_OP SHALL produce a >> b with fill from a[WIDTH-1]; when b >= WIDTH, y = WIDTH copies of a[WIDTH-1].
- REQ-023: A shift amount of b = 0 SHALL pass a through unchanged for all four shift ops.
- REQ-024: Any unassigned opcode SHALL produce y = 0, cout = 0 and overflow = 0, so that zero = 1.
- REQ-025: negative and zero SHALL be derived from the same result value that is registered into y, for every op.
- REQ-026: Opcode encodings SHALL be: ADD 4'h0, SUB 4'h1, AND 4'h2, OR 4'h3, XOR 4'h4, NOT 4'h5, LL_SHIFT 4'h6, LR_SHIFT 4'h7, AL_SHIFT 4'h8, AR_SHIFT 4'h9; 4'hA to 4'hF are unassigned.

Reset
- REQ-027: While rst = 1, the outputs SHALL be y = 0, cout = 0, overflow = 0, negative = 0 and zero = 1, independent of clk.
- REQ-028: On rst deassertion, the first rising clk edge SHALL register the current inputs; asserting rst mid-operation SHALL discard the pending result immediately.

Structure
- REQ-029: Package alu_ops SHALL hold the 4-bit opcode enum typedef and the constants ADD_OP, SUB_OP, AND_OP, OR_OP, XOR_OP, NOT_OP, LL_SHIFT_OP, LR_SHIFT_OP, AL_SHIFT_OP and AR_SHIFT_OP.
- REQ-030: ADD and SUB SHALL share one sub-module, alu_adder (a, b_eff, carry_in -> sum, carry, overflow), where SUB uses b_eff = ~b and carry_in = ~cin, and cout is the inverted carry.
- REQ-031: Shifts SHALL use a single barrel shifter selected by direction and fill.

Verification (WIDTH = 4; each check taken 1 cycle after applying stimulus)
- REQ-032: LL a=0001, b=0011 -> y=1000; AL a=1000, b=0001 -> y=0000, zero=1.
- REQ-033: LR a=1011, b=0001 -> y=0101; AR a=1001, b=0001 -> y=1100, negative=1; AR a=1110, b=0001 -> y=1111.
- REQ-034: NOT a=1010 -> y=0101; AND 1010,0111 -> y=0010; OR 1000,0100 -> y=1100; XOR 1100,1010 -> y=0110.
- REQ-035: SUB a=1000, b=0011, cin=1 -> y=0100, cout=0; SUB a=0000, b=0001, cin=0 -> y=1111, cout=1, negative=1.
- REQ-036: ADD a=0100, b=0110, cin=1 -> y=1011, cout=0, overflow=1; ADD a=1111, b=0001, cin=0 -> y=0000, cout=1, zero=1.
- REQ-037: Assert rst mid-stream with nonzero inputs -> y=0 and zero=1 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode encodings shared by the ALU and anything that drives it.
package alu_ops;

   typedef enum logic [3:0] {
      ADD_OP      = 4'h0,
      SUB_OP      = 4'h1,
      AND_OP      = 4'h2,
      OR_OP       = 4'h3,
      XOR_OP      = 4'h4,
      NOT_OP      = 4'h5,
      LL_SHIFT_OP = 4'h6,
      LR_SHIFT_OP = 4'h7,
      AL_SHIFT_OP = 4'h8,
      AR_SHIFT_OP = 4'h9
   } alu_op_e;

endpackage

// File: rtl/alu_adder.sv
// Shared adder for ADD and SUB: sum, carry out of the MSB and signed overflow.
module alu_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b_eff,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   logic [WIDTH:0] full;

   assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
   assign sum   = full[WIDTH-1:0];
   assign carry = full[WIDTH];
   // Overflow when both operands share a sign and the sum's sign differs.
   assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Single-cycle ALU with registered result and flags.
module alu
   import alu_ops::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             overflow,
   output logic             negative,
   output logic             zero
);

   localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [WIDTH-1:0] add_sum;
   logic             add_carry;
   logic             add_ovf;

   logic             sh_left;
   logic             sh_fill;
   logic [WIDTH-1:0] sh_in;
   logic [WIDTH-1:0] sh_rt;
   logic [WIDTH-1:0] sh_out;

   logic [WIDTH-1:0] res_d, y_q;
   logic             cout_d, cout_q;
   logic             ovf_d, ovf_q;
   logic             neg_d, neg_q;
   logic             zero_d, zero_q;

   // SUB is a + ~b + ~cin; the adder's carry then means "no borrow".
   assign is_sub  = (opcode == SUB_OP);
   assign b_eff   = is_sub ? ~b : b;
   assign cin_eff = is_sub ? ~cin : cin;

   alu_adder #(.WIDTH(WIDTH)) u_adder (
      .a        (a),
      .b_eff    (b_eff),
      .carry_in (cin_eff),
      .sum      (add_sum),
      .carry    (add_carry),
      .overflow (add_ovf)
   );

   // One right-shifting barrel shifter; left shifts reverse bits in and out.
   always_comb begin
      sh_left = (opcode == LL_SHIFT_OP) || (opcode == AL_SHIFT_OP);
      sh_fill = (opcode == AR_SHIFT_OP) && a[WIDTH-1];
      sh_in   = '0;
      sh_out  = '0;
      for (int i = 0; i < WIDTH; i++)
         sh_in[i] = sh_left ? a[WIDTH-1-i] : a[i];
      if (b >= W_LIM)
         sh_rt = {WIDTH{sh_fill}};
      else
         sh_rt = WIDTH'({{WIDTH{sh_fill}}, sh_in} >> b);
      for (int i = 0; i < WIDTH; i++)
         sh_out[i] = sh_left ? sh_rt[WIDTH-1-i] : sh_rt[i];
   end

   // Result and flag selection; unassigned opcodes fall through to zero.
   always_comb begin
      res_d  = '0;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
      case (opcode)
         ADD_OP: begin
            res_d  = add_sum;
            cout_d = add_carry;
            ovf_d  = add_ovf;
         end
         SUB_OP: begin
            res_d  = add_sum;
            cout_d = ~add_carry;
            ovf_d  = add_ovf;
         end
         AND_OP:      res_d = a & b;
         OR_OP:       res_d = a | b;
         XOR_OP:      res_d = a ^ b;
         NOT_OP:      res_d = ~a;
         LL_SHIFT_OP,
         LR_SHIFT_OP,
         AL_SHIFT_OP,
         AR_SHIFT_OP: res_d = sh_out;
         default:     res_d = '0;
      endcase
      neg_d  = res_d[WIDTH-1];
      zero_d = (res_d == '0);
   end

   // Output register; reset forces the "result is zero" state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         neg_q  <= 1'b0;
         zero_q <= 1'b1;
      end else begin
         y_q    <= res_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         neg_q  <= neg_d;
         zero_q <= zero_d;
      end
   end

   assign y        = y_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
   assign negative = neg_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the ALU at WIDTH = 4.
module tb_alu;

   localparam int W = 4;

   typedef struct {
      string      name;
      logic [3:0] y;
      logic       c, v, n, z;
   } exp_t;

   typedef struct {
      string      name;
      logic [3:0] op, a, b;
      logic       cin;
      logic [3:0] y;
      logic       c, v, n, z;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   opcode;
   logic [W-1:0] a, b;
   logic         cin;
   logic [W-1:0] y;
   logic         cout, overflow, negative, zero;

   int checks = 0;
   int errors = 0;
   exp_t scb[$];

   alu #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .opcode   (opcode),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .y        (y),
      .cout     (cout),
      .overflow (overflow),
      .negative (negative),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   // Reference model written with plain integer arithmetic.
   function automatic exp_t model(input logic [3:0] op, input logic [3:0] av,
                                  input logic [3:0] bv, input logic ci);
      exp_t e;
      int ua, ub, sa, sbv, r, sr;
      ua = int'(av);
      ub = int'(bv);
      sa = $signed(av);
      sbv = $signed(bv);
      r = 0;
      e.name = "rand";
      e.c = 1'b0;
      e.v = 1'b0;
      case (op)
         4'h0: begin
            r = ua + ub + int'(ci);
            e.c = (r > 15);
            sr = sa + sbv + int'(ci);
            e.v = (sr > 7) || (sr < -8);
         end
         4'h1: begin
            r = ua - ub - int'(ci);
            e.c = (ua < ub + int'(ci));
            sr = sa - sbv - int'(ci);
            e.v = (sr > 7) || (sr < -8);
         end
         4'h2: r = ua & ub;
         4'h3: r = ua | ub;
         4'h4: r = ua ^ ub;
         4'h5: r = ~ua;
         4'h6, 4'h8: r = (ub >= W) ? 0 : (ua << ub);
         4'h7: r = (ub >= W) ? 0 : (ua >> ub);
         4'h9: r = sa >>> ((ub >= W) ? W - 1 : ub);
         default: r = 0;
      endcase
      e.y = r[3:0];
      e.n = e.y[3];
      e.z = (e.y == 4'h0);
      return e;
   endfunction

   task automatic drive(input logic [3:0] op, input logic [3:0] av,
                        input logic [3:0] bv, input logic ci);
      opcode = op;
      a      = av;
      b      = bv;
      cin    = ci;
   endtask

   task automatic test_reset;
      logic [7:0] obs;
      rst = 1'b1;
      drive(4'h0, 4'h7, 4'h5, 1'b1);
      #3;
      obs = {y, cout, overflow, negative, zero};
      checks++;
      if (obs !== 8'b0000_0001) begin
         errors++;
         $display("FAIL reset_state got=%b exp=%b", obs, 8'b0000_0001);
      end
      @(posedge clk);
      #1;
      obs = {y, cout, overflow, negative, zero};
      checks++;
      if (obs !== 8'b0000_0001) begin
         errors++;
         $display("FAIL reset_held_over_edge got=%b exp=%b", obs, 8'b0000_0001);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed;
      vec_t t[24];
      exp_t e;
      logic [7:0] obs, expv;
      t[0]  = '{"ll_0001_3",   4'h6, 4'b0001, 4'd3, 1'b0, 4'b1000, 0, 0, 1, 0};
      t[1]  = '{"al_1000_1",   4'h8, 4'b1000, 4'd1, 1'b0, 4'b0000, 0, 0, 0, 1};
      t[2]  = '{"lr_1011_1",   4'h7, 4'b1011, 4'd1, 1'b0, 4'b0101, 0, 0, 0, 0};
      t[3]  = '{"ar_1001_1",   4'h9, 4'b1001, 4'd1, 1'b0, 4'b1100, 0, 0, 1, 0};
      t[4]  = '{"ar_1110_1",   4'h9, 4'b1110, 4'd1, 1'b0, 4'b1111, 0, 0, 1, 0};
      t[5]  = '{"not_1010",    4'h5, 4'b1010, 4'b0000, 1'b0, 4'b0101, 0, 0, 0, 0};
      t[6]  = '{"and",         4'h2, 4'b1010, 4'b0111, 1'b0, 4'b0010, 0, 0, 0, 0};
      t[7]  = '{"or",          4'h3, 4'b1000, 4'b0100, 1'b0, 4'b1100, 0, 0, 1, 0};
      t[8]  = '{"xor",         4'h4, 4'b1100, 4'b1010, 1'b0, 4'b0110, 0, 0, 0, 0};
      t[9]  = '{"sub_8_3_1",   4'h1, 4'b1000, 4'b0011, 1'b1, 4'b0100, 0, 1, 0, 0};
      t[10] = '{"sub_0_1_0",   4'h1, 4'b0000, 4'b0001, 1'b0, 4'b1111, 1, 0, 1, 0};
      t[11] = '{"add_4_6_1",   4'h0, 4'b0100, 4'b0110, 1'b1, 4'b1011, 0, 1, 1, 0};
      t[12] = '{"add_15_1_0",  4'h0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1, 0, 0, 1};
      t[13] = '{"ll_b_eq_w",   4'h6, 4'b1111, 4'd4, 1'b0, 4'b0000, 0, 0, 0, 1};
      t[14] = '{"lr_b_15",     4'h7, 4'b1111, 4'd15, 1'b0, 4'b0000, 0, 0, 0, 1};
      t[15] = '{"ar_neg_b7",   4'h9, 4'b1000, 4'd7, 1'b0, 4'b1111, 0, 0, 1, 0};
      t[16] = '{"ar_pos_b15",  4'h9, 4'b0111, 4'd15, 1'b0, 4'b0000, 0, 0, 0, 1};
      t[17] = '{"lr_b0",       4'h7, 4'b1011, 4'd0, 1'b0, 4'b1011, 0, 0, 1, 0};
      t[18] = '{"ar_b0",       4'h9, 4'b1001, 4'd0, 1'b0, 4'b1001, 0, 0, 1, 0};
      t[19] = '{"al_b0",       4'h8, 4'b0110, 4'd0, 1'b0, 4'b0110, 0, 0, 0, 0};
      t[20] = '{"not_ign_b",   4'h5, 4'b0000, 4'b1111, 1'b1, 4'b1111, 0, 0, 1, 0};
      t[21] = '{"and_ign_cin", 4'h2, 4'b1111, 4'b1111, 1'b1, 4'b1111, 0, 0, 1, 0};
      t[22] = '{"unassigned_a",4'hA, 4'b1111, 4'b1111, 1'b1, 4'b0000, 0, 0, 0, 1};
      t[23] = '{"unassigned_f",4'hF, 4'b0111, 4'b0001, 1'b1, 4'b0000, 0, 0, 0, 1};
      foreach (t[i]) begin
         @(negedge clk);
         drive(t[i].op, t[i].a, t[i].b, t[i].cin);
         scb.push_back('{t[i].name, t[i].y, t[i].c, t[i].v, t[i].n, t[i].z});
         @(posedge clk);
         #1;
         e = scb.pop_front();
         obs  = {y, cout, overflow, negative, zero};
         expv = {e.y, e.c, e.v, e.n, e.z};
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", e.name, obs, expv);
         end
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      logic [7:0] obs, expv;
      logic [3:0] op, av, bv;
      logic ci;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         op = 4'($urandom_range(0, 15));
         av = 4'($urandom);
         bv = 4'($urandom);
         ci = 1'($urandom);
         drive(op, av, bv, ci);
         e = model(op, av, bv, ci);
         e.name = $sformatf("b2b_op%h_a%b_b%b_c%b", op, av, bv, ci);
         scb.push_back(e);
         @(posedge clk);
         #1;
         e = scb.pop_front();
         obs  = {y, cout, overflow, negative, zero};
         expv = {e.y, e.c, e.v, e.n, e.z};
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", e.name, obs, expv);
         end
      end
   endtask

   task automatic test_reset_mid;
      exp_t e;
      logic [7:0] obs, expv;
      @(negedge clk);
      drive(4'h3, 4'b1010, 4'b0101, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      obs = {y, cout, overflow, negative, zero};
      checks++;
      if (obs !== 8'b0000_0001) begin
         errors++;
         $display("FAIL reset_mid_async got=%b exp=%b", obs, 8'b0000_0001);
      end
      @(negedge clk);
      drive(4'h0, 4'b0011, 4'b0100, 1'b1);
      rst = 1'b0;
      e = model(4'h0, 4'b0011, 4'b0100, 1'b1);
      e.name = "first_edge_after_reset";
      scb.push_back(e);
      @(posedge clk);
      #1;
      e = scb.pop_front();
      obs  = {y, cout, overflow, negative, zero};
      expv = {e.y, e.c, e.v, e.n, e.z};
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", e.name, obs, expv);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
